// File: rtl/data_mem_responder_if.sv
// Load/store bus between the datapath (master) and the data memory responder (slave).
interface data_mem_responder_if;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        mem_write;
   logic        mem_read;
   logic [2:0]  funct3;
   logic [31:0] rdata;
   logic        stall;
   logic        misaligned;
   logic        wb_empty;

   modport master (
      output addr, wdata, mem_write, mem_read, funct3,
      input  rdata, stall, misaligned, wb_empty
   );

   modport slave (
      input  addr, wdata, mem_write, mem_read, funct3,
      output rdata, stall, misaligned, wb_empty
   );
endinterface

// File: rtl/data_mem_responder.sv
// Data memory with a 4-entry store buffer draining one entry per DRAIN_CYCLES cycles.
// Define DMEM_STORE_FORWARD_EN to forward buffered stores to loads instead of stalling them.
module data_mem_responder #(
   parameter int unsigned DEPTH_WORDS  = 1024,
   parameter int unsigned DRAIN_CYCLES = 2
) (
   input logic                 clk,
   input logic                 reset,
   data_mem_responder_if.slave bus
);
   localparam int unsigned AW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [3:0]  DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

   localparam logic [2:0] F_B  = 3'b000;
   localparam logic [2:0] F_H  = 3'b001;
   localparam logic [2:0] F_W  = 3'b010;
   localparam logic [2:0] F_BU = 3'b100;
   localparam logic [2:0] F_HU = 3'b101;

   logic [31:0]   mem [DEPTH_WORDS];
   logic [AW-1:0] sb_addr [4];
   logic [31:0]   sb_data [4];
   logic [3:0]    sb_be [4];
   logic [1:0]    head, tail;
   logic [2:0]    count;
   logic [3:0]    drain_cnt;

   logic [29:0]   word_full;
   logic [AW-1:0] widx;
   logic          bad_access, is_load, match_any, load_stall, full_stall;
   logic          accept, commit;
   logic [3:0]    st_be;
   logic [31:0]   st_data, load_word, shifted, ext;

   always_comb begin
      word_full = bus.addr[31:2];
      widx      = AW'(word_full % 30'(DEPTH_WORDS));
      is_load   = bus.mem_read & ~bus.mem_write;

      case (bus.funct3)
         F_B, F_BU: bad_access = 1'b0;
         F_H, F_HU: bad_access = bus.addr[0];
         F_W:       bad_access = (bus.addr[1:0] != 2'b00);
         default:   bad_access = 1'b1;
      endcase

      case (bus.funct3)
         F_B: begin
            st_be   = 4'b0001 << bus.addr[1:0];
            st_data = {4{bus.wdata[7:0]}};
         end
         F_H: begin
            st_be   = 4'b0011 << bus.addr[1:0];
            st_data = {2{bus.wdata[15:0]}};
         end
         default: begin
            st_be   = 4'b1111;
            st_data = bus.wdata;
         end
      endcase

      // Walk oldest to youngest so the youngest matching entry wins each byte.
      match_any = 1'b0;
      load_word = mem[widx];
      for (int unsigned i = 0; i < 4; i++) begin
         if ((3'(i) < count) && (sb_addr[head + 2'(i)] == widx)) begin
            match_any = 1'b1;
            for (int unsigned b = 0; b < 4; b++) begin
               if (sb_be[head + 2'(i)][b]) begin
                  load_word[8*b +: 8] = sb_data[head + 2'(i)][8*b +: 8];
               end
            end
         end
      end

`ifdef DMEM_STORE_FORWARD_EN
      load_stall = 1'b0;
`else
      load_stall = is_load & match_any;
`endif
      full_stall = bus.mem_write & (count == 3'd4);

      shifted = load_word >> {bus.addr[1:0], 3'b000};
      case (bus.funct3)
         F_B:     ext = {{24{shifted[7]}}, shifted[7:0]};
         F_BU:    ext = {24'd0, shifted[7:0]};
         F_H:     ext = {{16{shifted[15]}}, shifted[15:0]};
         F_HU:    ext = {16'd0, shifted[15:0]};
         default: ext = load_word;
      endcase

      accept = bus.mem_write & ~full_stall & ~bad_access;
      commit = (count != 3'd0) & (drain_cnt == DRAIN_LAST);

      bus.stall      = full_stall | load_stall;
      bus.misaligned = (bus.mem_read | bus.mem_write) & bad_access;
      bus.rdata      = (is_load & ~bad_access) ? ext : '0;
      bus.wb_empty   = (count == 3'd0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         drain_cnt <= '0;
      end else begin
         if (accept) tail <= tail + 2'd1;
         if (commit) begin
            head      <= head + 2'd1;
            drain_cnt <= '0;
         end else if (count != 3'd0) begin
            drain_cnt <= drain_cnt + 4'd1;
         end else begin
            drain_cnt <= '0;
         end
         case ({accept, commit})
            2'b10:   count <= count + 3'd1;
            2'b01:   count <= count - 3'd1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         sb_addr[tail] <= widx;
         sb_data[tail] <= st_data;
         sb_be[tail]   <= st_be;
      end
   end

   // The array is never reset; a head caught mid-drain by reset is simply dropped.
   always_ff @(posedge clk) begin
      if (commit && !reset) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (sb_be[head][b]) begin
               mem[sb_addr[head]][8*b +: 8] <= sb_data[head][8*b +: 8];
            end
         end
      end
   end
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: dut_a uses DRAIN_CYCLES=2, dut_b uses DRAIN_CYCLES=4 and a 64-word array.
module tb_data_mem_responder;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010, BU = 3'b100, HU = 3'b101;

   always #5 clk = ~clk;

   data_mem_responder_if ifa ();
   data_mem_responder_if ifb ();

   data_mem_responder #(.DEPTH_WORDS(1024), .DRAIN_CYCLES(2)) dut_a (
      .clk(clk), .reset(reset), .bus(ifa)
   );
   data_mem_responder #(.DEPTH_WORDS(64), .DRAIN_CYCLES(4)) dut_b (
      .clk(clk), .reset(reset), .bus(ifb)
   );

   task automatic drv_a(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d);
      ifa.mem_read = rd; ifa.mem_write = wr; ifa.funct3 = f3; ifa.addr = a; ifa.wdata = d;
   endtask

   task automatic drv_b(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d);
      ifb.mem_read = rd; ifb.mem_write = wr; ifb.funct3 = f3; ifb.addr = a; ifb.wdata = d;
   endtask

   // Idles the bus and counts cycles until the buffer drains (limit 50).
   task automatic wait_empty_a(output int cyc);
      cyc = 0;
      @(negedge clk); drv_a(0, 0, W, 0, 0); #1;
      while (ifa.wb_empty !== 1'b1 && cyc < 50) begin
         cyc++;
         @(negedge clk); #1;
      end
   endtask

   task automatic wait_empty_b(output int cyc);
      cyc = 0;
      @(negedge clk); drv_b(0, 0, W, 0, 0); #1;
      while (ifb.wb_empty !== 1'b1 && cyc < 50) begin
         cyc++;
         @(negedge clk); #1;
      end
   endtask

   task automatic test_reset;
      drv_a(0, 0, W, 0, 0);
      drv_b(0, 0, W, 0, 0);
      reset = 1'b1;
      @(negedge clk); @(negedge clk);
      reset = 1'b0;
      #1;
      checks++; if (ifa.stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", ifa.stall); end
      checks++; if (ifa.wb_empty !== 1'b1) begin errors++; $display("FAIL reset_wb_empty_a: got %b want 1", ifa.wb_empty); end
      checks++; if (ifb.wb_empty !== 1'b1) begin errors++; $display("FAIL reset_wb_empty_b: got %b want 1", ifb.wb_empty); end
      checks++; if (ifa.rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", ifa.rdata); end
      checks++; if (ifa.misaligned !== 1'b0) begin errors++; $display("FAIL reset_misaligned: got %b want 0", ifa.misaligned); end
   endtask

   task automatic test_store_load;
      int n;
      @(negedge clk); drv_a(0, 1, W, 32'h10, 32'hDEADBEEF); #1;
      checks++; if (ifa.stall !== 1'b0) begin errors++; $display("FAIL sw_accept_stall: got %b want 0", ifa.stall); end
      @(negedge clk); drv_a(1, 0, W, 32'h10, 0); #1;
      checks++; if (ifa.wb_empty !== 1'b0) begin errors++; $display("FAIL sw_pending: got %b want 0", ifa.wb_empty); end
`ifdef DMEM_STORE_FORWARD_EN
      checks++; if (ifa.stall !== 1'b0) begin errors++; $display("FAIL lw_fwd_stall: got %b want 0", ifa.stall); end
      checks++; if (ifa.rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_fwd_rdata: got %h want deadbeef", ifa.rdata); end
`else
      n = 0;
      while (ifa.stall === 1'b1 && n < 10) begin
         n++;
         @(negedge clk); #1;
      end
      checks++; if (n !== 2) begin errors++; $display("FAIL lw_stall_cycles: got %0d want 2", n); end
      checks++; if (ifa.rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_after_commit: got %h want deadbeef", ifa.rdata); end
`endif
      wait_empty_a(n);
      checks++; if (n >= 50) begin errors++; $display("FAIL drain_timeout_a1: got %0d cycles want <50", n); end
   endtask

   task automatic test_load_ext;
      int n;
      logic [2:0]  f3s  [8] = '{B, BU, H, HU, W, B, HU, BU};
      logic [31:0] adrs [8] = '{32'h10, 32'h11, 32'h10, 32'h10, 32'h10, 32'h11, 32'h12, 32'h10};
      logic [31:0] exps [8] = '{32'hFFFFFFF0, 32'h00000080, 32'hFFFF80F0, 32'h000080F0,
                                32'h000080F0, 32'hFFFFFF80, 32'h00000000, 32'h000000F0};
      @(negedge clk); drv_a(0, 1, W, 32'h10, 32'h000080F0); #1;
      wait_empty_a(n);
      checks++; if (n >= 50) begin errors++; $display("FAIL drain_timeout_a2: got %0d cycles want <50", n); end
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); drv_a(1, 0, f3s[i], adrs[i], 0); #1;
         checks++;
         if (ifa.rdata !== exps[i]) begin
            errors++;
            $display("FAIL load_ext[%0d] f3=%b addr=%h: got %h want %h", i, f3s[i], adrs[i], ifa.rdata, exps[i]);
         end
      end
   endtask

   task automatic test_forward_merge;
      int n;
      @(negedge clk); drv_a(0, 1, W, 32'h20, 32'h11223344); #1;
      @(negedge clk); drv_a(0, 1, B, 32'h21, 32'h000000AA); #1;
      checks++; if (ifa.stall !== 1'b0) begin errors++; $display("FAIL sb_accept_stall: got %b want 0", ifa.stall); end
      @(negedge clk); drv_a(1, 0, W, 32'h20, 0); #1;
`ifdef DMEM_STORE_FORWARD_EN
      checks++; if (ifa.stall !== 1'b0) begin errors++; $display("FAIL merge_fwd_stall: got %b want 0", ifa.stall); end
`else
      n = 0;
      while (ifa.stall === 1'b1 && n < 10) begin
         n++;
         @(negedge clk); #1;
      end
      checks++; if (n !== 3) begin errors++; $display("FAIL merge_stall_cycles: got %0d want 3", n); end
`endif
      checks++; if (ifa.rdata !== 32'h1122AA44) begin errors++; $display("FAIL merge_rdata: got %h want 1122aa44", ifa.rdata); end
      wait_empty_a(n);
      checks++; if (n >= 50) begin errors++; $display("FAIL drain_timeout_a3: got %0d cycles want <50", n); end
   endtask

   task automatic test_misaligned;
      logic [2:0]  f3s  [5] = '{H, 3'b011, HU, 3'b110, 3'b111};
      logic [31:0] adrs [5] = '{32'h13, 32'h20, 32'h21, 32'h20, 32'h20};
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); drv_a(1, 0, f3s[i], adrs[i], 0); #1;
         checks++; if (ifa.misaligned !== 1'b1) begin errors++; $display("FAIL mis_load_flag[%0d]: got %b want 1", i, ifa.misaligned); end
         checks++; if (ifa.rdata !== 32'h0) begin errors++; $display("FAIL mis_load_rdata[%0d]: got %h want 0", i, ifa.rdata); end
      end
      @(negedge clk); drv_a(1, 0, W, 32'h20, 0); #1;
      checks++; if (ifa.misaligned !== 1'b0) begin errors++; $display("FAIL aligned_flag: got %b want 0", ifa.misaligned); end
      @(negedge clk); drv_a(0, 1, W, 32'h22, 32'hFFFFFFFF); #1;
      checks++; if (ifa.misaligned !== 1'b1) begin errors++; $display("FAIL mis_sw_flag: got %b want 1", ifa.misaligned); end
      checks++; if (ifa.stall !== 1'b0) begin errors++; $display("FAIL mis_sw_stall: got %b want 0", ifa.stall); end
      @(negedge clk); drv_a(0, 1, H, 32'h23, 32'hFFFFFFFF); #1;
      checks++; if (ifa.misaligned !== 1'b1) begin errors++; $display("FAIL mis_sh_flag: got %b want 1", ifa.misaligned); end
      @(negedge clk); drv_a(0, 0, W, 0, 0); #1;
      checks++; if (ifa.wb_empty !== 1'b1) begin errors++; $display("FAIL mis_no_enqueue: got %b want 1", ifa.wb_empty); end
      @(negedge clk); drv_a(1, 0, W, 32'h20, 0); #1;
      checks++; if (ifa.rdata !== 32'h1122AA44) begin errors++; $display("FAIL mis_no_write: got %h want 1122aa44", ifa.rdata); end
   endtask

   task automatic test_back_to_back;
      int n;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk); drv_b(0, 1, W, 32'(4 * k), 32'hA0000000 + 32'(k)); #1;
         if (k < 4) begin
            checks++; if (ifb.stall !== 1'b0) begin errors++; $display("FAIL b2b_accept[%0d]: stall got %b want 0", k, ifb.stall); end
         end else begin
            n = 0;
            while (ifb.stall === 1'b1 && n < 10) begin
               n++;
               @(negedge clk); #1;
            end
            checks++; if (n !== 1) begin errors++; $display("FAIL b2b_full_stall_cycles: got %0d want 1", n); end
         end
      end
      @(negedge clk); drv_b(0, 0, W, 0, 0); #1;
      checks++; if (ifb.wb_empty !== 1'b0) begin errors++; $display("FAIL b2b_pending: got %b want 0", ifb.wb_empty); end
      wait_empty_b(n);
      checks++; if (n >= 50) begin errors++; $display("FAIL drain_timeout_b1: got %0d cycles want <50", n); end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk); drv_b(1, 0, W, 32'(4 * k), 0); #1;
         checks++;
         if (ifb.rdata !== 32'hA0000000 + 32'(k)) begin
            errors++;
            $display("FAIL b2b_readback[%0d]: got %h want %h", k, ifb.rdata, 32'hA0000000 + 32'(k));
         end
      end
      // 0x100 is word 64, which wraps to word 0 in a 64-word array
      @(negedge clk); drv_b(1, 0, W, 32'h100, 0); #1;
      checks++; if (ifb.rdata !== 32'hA0000000) begin errors++; $display("FAIL addr_wrap: got %h want a0000000", ifb.rdata); end
   endtask

   task automatic test_reset_discard;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); drv_b(0, 1, W, 32'(4 * k), 32'h55550000 + 32'(k)); #1;
         checks++; if (ifb.stall !== 1'b0) begin errors++; $display("FAIL rd_accept[%0d]: stall got %b want 0", k, ifb.stall); end
      end
      @(negedge clk); drv_b(0, 0, W, 0, 0); #1;
      @(negedge clk); reset = 1'b1; #1;
      checks++; if (ifb.wb_empty !== 1'b0) begin errors++; $display("FAIL rd_pending_before_reset: got %b want 0", ifb.wb_empty); end
      @(negedge clk); reset = 1'b0; #1;
      checks++; if (ifb.wb_empty !== 1'b1) begin errors++; $display("FAIL rd_wb_empty: got %b want 1", ifb.wb_empty); end
      checks++; if (ifb.stall !== 1'b0) begin errors++; $display("FAIL rd_stall: got %b want 0", ifb.stall); end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk); drv_b(1, 0, W, 32'(4 * k), 0); #1;
         checks++;
         if (ifb.rdata !== 32'hA0000000 + 32'(k)) begin
            errors++;
            $display("FAIL rd_retained[%0d]: got %h want %h", k, ifb.rdata, 32'hA0000000 + 32'(k));
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_store_load();
      test_load_ext();
      test_forward_merge();
      test_misaligned();
      test_back_to_back();
      test_reset_discard();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning data array size in 32-bit words; address wraps modulo DEPTH_WORDS.
REQ-002 SHALL have parameter DRAIN_CYCLES, default 2, meaning cycles needed to commit one buffered store to the array (range 1-15).
REQ-003 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port addr  input  32  byte address (datapath ALU result).
REQ-006 SHALL have port wdata  input  32  store data (datapath rs2 value).
REQ-007 SHALL have port mem_write  input  1  store request this cycle.
REQ-008 SHALL have port mem_read  input  1  load request this cycle.
REQ-009 SHALL have port funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 SHALL have port rdata  output  32  load data, combinational, same cycle as request.
REQ-011 SHALL have port stall  output  1  request not accepted; requester holds all inputs.
REQ-012 SHALL have port misaligned  output  1  current request not naturally aligned, or funct3 invalid.
REQ-013 SHALL have port wb_empty  output  1  store buffer holds no pending entries.

Function
REQ-014 SHALL contain a 4-entry FIFO store buffer; each entry holds word address, 32-bit data, and 4-bit byte enable.
REQ-015 An accepted store (mem_write=1, stall=0, misaligned=0) SHALL enqueue at the rising edge: SB enable 0001<<addr[1:0], SH 0011<<addr[1:0], SW 1111; data replicated into the selected lanes.
REQ-016 SHALL commit the head entry to the array after DRAIN_CYCLES consecutive non-empty cycles, counted by a drain counter; only enabled bytes are written; the counter restarts at 0 after each commit.
REQ-017 stall SHALL be 1 when mem_write=1 and the registered occupancy is 4; a commit in the same cycle does not clear stall until the next cycle.
REQ-018 An enqueue and a commit in the same cycle SHALL leave occupancy unchanged; pointers wrap modulo 4.
REQ-019 Loads SHALL read the array combinationally, extract by funct3 and addr[1:0], and sign-extend (B, H) or zero-extend (BU, HU).
REQ-020 misaligned SHALL be 1 for H/HU with addr[0]=1, W with addr[1:0]!=0, or funct3 in {011,110,111}; that store SHALL NOT be enqueued and rdata SHALL be 0.
REQ-021 rdata SHALL be 0 when mem_read=0; mem_read and mem_write both 1 SHALL be treated as a store only.
REQ-022 wb_empty SHALL be 1 when occupancy is 0.

Reset
REQ-023 Reset SHALL clear occupancy, both pointers, and the drain counter in the same cycle it is sampled; pending stores SHALL be discarded, including a mid-drain head.
REQ-024 Array contents SHALL NOT be cleared by reset.
REQ-025 After reset: stall=0, wb_empty=1, misaligned and rdata follow inputs.

Configuration
REQ-026 With macro DMEM_STORE_FORWARD_EN defined, loads SHALL merge matching buffer entries byte-wise over the array word, youngest entry winning per byte, with no stall.
REQ-027 With DMEM_STORE_FORWARD_EN undefined, a load whose word address matches any valid entry SHALL assert stall until no entry matches; rdata is don't-care while stalled.

Verification
REQ-028 Reset; SW 0xDEADBEEF to 0x10; LW 0x10 next cycle -> forward on: rdata=0xDEADBEEF, stall=0; forward off: stall=1 until the commit at DRAIN_CYCLES=2, then 0xDEADBEEF.
REQ-029 Array word 0x10 = 0x000080F0; LB 0x10 -> 0xFFFFFFF0; LBU 0x11 -> 0x00000080; LH 0x10 -> 0xFFFF80F0; LHU 0x10 -> 0x000080F0.
REQ-030 Five back-to-back SW, DRAIN_CYCLES=4 -> stores 1-4 accepted, 5th sees stall=1 until occupancy<4, then accepted; wb_empty=1 after all commits.
REQ-031 SW 0x11223344 then SB 0xAA to 0x21 (both word 0x20), forward on; LW 0x20 -> 0x1122AA44.
REQ-032 LH 0x13, SW 0x22 -> misaligned=1, rdata=0, occupancy unchanged.
REQ-033 Three stores pending, reset asserted one cycle -> wb_empty=1 next cycle; array words at the three addresses retain their prior values.
